lcd_display_sequencer: RTL and testbench

//  Drives the LCD instruction engine (the 4-bit SF_D transfer block) with a command stream.

---
 rtl/lcd_display_sequencer_pkg.sv | 56 +++++
 rtl/lcd_msg_buf.sv | 27 ++
 rtl/lcd_display_sequencer.sv | 141 ++++++++++++++
 tb/tb_lcd_display_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_display_sequencer_pkg.sv
// Shared LCD command constants, db field layout, sequencer states and step decode helpers.
// Pure definitions: no latency, no flow control.
package lcd_display_sequencer_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h28;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  localparam int DB_RS = 9;
  localparam int DB_RW = 8;

  localparam logic [5:0] INIT_LAST   = 6'd3;
  localparam logic [5:0] REDRAW_LAST = 6'd33;
  localparam logic [5:0] LINE2_STEP  = 6'd17;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_IDLE,
    ST_START
  } seq_state_t;

  // Redraw step -> buffer index: step 0 and step 17 are the line address commands.
  function automatic logic [4:0] char_addr(input logic [5:0] step);
    return (step < LINE2_STEP) ? 5'(step - 6'd1) : 5'(step - 6'd2);
  endfunction

  function automatic logic [9:0] step_db(input logic redraw, input logic [5:0] step,
                                         input logic [7:0] ch);
    logic [9:0] d;
    d = '0;
    if (!redraw) begin
      case (step[1:0])
        2'd0:    d[7:0] = LCD_FUNC_SET;
        2'd1:    d[7:0] = LCD_ENTRY;
        2'd2:    d[7:0] = LCD_DISP_ON;
        default: d[7:0] = LCD_CLEAR;
      endcase
    end else if (step == 6'd0) begin
      d[7:0] = LCD_LINE1;
    end else if (step == LINE2_STEP) begin
      d[7:0] = LCD_LINE2;
    end else begin
      d[DB_RS] = 1'b1;
      d[7:0]   = ch;
    end
    return d;
  endfunction

endpackage

// File: rtl/lcd_msg_buf.sv
// 32x8 message buffer: synchronous write, combinational read (same-cycle read sees old data).
// Reset fills every entry with ASCII space; writes are never refused.
module lcd_msg_buf
  import lcd_display_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= CHAR_SPACE;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_display_sequencer.sv
// Feeds the LCD instruction engine: power-up wait, init list, then 2x16 redraws on refresh.
// Next request leaves exactly settle+1 cycles after done; refreshes while busy coalesce into one.
module lcd_display_sequencer
  import lcd_display_sequencer_pkg::*;
#(
  parameter int unsigned T_PWRUP      = 750000,
  parameter int unsigned T_CMD        = 2000,
  parameter int unsigned T_CLEAR      = 82000,
  parameter bit          BOOT_REFRESH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msg_we,
  input  logic [4:0] msg_waddr,
  input  logic [7:0] msg_wdata,
  input  logic       refresh,
  output logic       busy,
  output logic       init_done,
  output logic [9:0] db,
  output logic       next_instruction,
  input  logic       done
);

  localparam logic [19:0] PWRUP_LAST = 20'(T_PWRUP - 1);
  localparam logic [19:0] CMD_LAST   = 20'(T_CMD - 1);
  localparam logic [19:0] CLEAR_LAST = 20'(T_CLEAR - 1);

  seq_state_t  state;
  logic [19:0] cnt;
  logic [5:0]  step;
  logic        redraw;
  logic        pending;

  logic [5:0]  next_step;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_char;
  logic [19:0] settle_last;
  logic        list_end;
  logic        want_redraw;

  // The char for the upcoming step is looked up in the cycle that registers it into db.
  assign next_step   = (state == ST_SETTLE) ? 6'(step + 6'd1) : step;
  assign rd_addr     = char_addr(next_step);
  assign settle_last = (!db[DB_RS] && db[7:0] == LCD_CLEAR) ? CLEAR_LAST : CMD_LAST;
  assign list_end    = redraw ? (step == REDRAW_LAST) : (step == INIT_LAST);
  assign want_redraw = pending | refresh;

  lcd_msg_buf u_msg_buf (
    .clk   (clk),
    .reset (reset),
    .we    (msg_we),
    .waddr (msg_waddr),
    .wdata (msg_wdata),
    .raddr (rd_addr),
    .rdata (rd_char)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_PWRUP;
      cnt              <= '0;
      step             <= '0;
      redraw           <= 1'b0;
      pending          <= 1'b0;
      db               <= '0;
      next_instruction <= 1'b0;
      busy             <= 1'b1;
      init_done        <= 1'b0;
    end else begin
      next_instruction <= 1'b0;
      if (refresh) pending <= 1'b1;

      case (state)
        ST_PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            cnt              <= '0;
            step             <= '0;
            redraw           <= 1'b0;
            db               <= step_db(1'b0, 6'd0, rd_char);
            next_instruction <= 1'b1;
            state            <= ST_ISSUE;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        ST_ISSUE: state <= ST_WAIT_DONE;

        ST_WAIT_DONE: begin
          if (done) state <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (cnt == settle_last) begin
            cnt <= '0;
            if (list_end) begin
              if (!redraw) init_done <= 1'b1;
              if (want_redraw || (!redraw && BOOT_REFRESH)) begin
                pending          <= 1'b0;
                redraw           <= 1'b1;
                step             <= '0;
                db               <= step_db(1'b1, 6'd0, rd_char);
                next_instruction <= 1'b1;
                state            <= ST_ISSUE;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end else begin
              step             <= next_step;
              db               <= step_db(redraw, next_step, rd_char);
              next_instruction <= 1'b1;
              state            <= ST_ISSUE;
            end
          end else begin
            cnt <= cnt + 20'd1;
          end
        end

        ST_IDLE: begin
          if (want_redraw) begin
            pending <= 1'b0;
            busy    <= 1'b1;
            redraw  <= 1'b1;
            step    <= '0;
            state   <= ST_START;
          end
        end

        ST_START: begin
          db               <= step_db(1'b1, 6'd0, rd_char);
          next_instruction <= 1'b1;
          state            <= ST_ISSUE;
        end

        default: state <= ST_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_display_sequencer.sv
// Two sequencers (auto redraw on / off) driven against an engine model that answers 40 cycles late.
// Expected command streams and timing come from a line/column model of the display.
module tb_lcd_display_sequencer;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       reset_a, msg_we_a, refresh_a, busy_a, init_done_a, ni_a, done_a, stray_a;
  logic [4:0] msg_waddr_a;
  logic [7:0] msg_wdata_a;
  logic [9:0] db_a;
  logic       reset_b, msg_we_b, refresh_b, busy_b, init_done_b, ni_b, done_b;
  logic [4:0] msg_waddr_b;
  logic [7:0] msg_wdata_b;
  logic [9:0] db_b;

  logic [9:0] q_a[$], q_b[$], exp_a[$], exp_b[$];
  int         tq_a[$], tq_b[$];
  int         done_at_a = -1, done_at_b = -1;
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];

  lcd_display_sequencer #(.T_PWRUP(100), .T_CMD(20), .T_CLEAR(50), .BOOT_REFRESH(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .msg_we(msg_we_a), .msg_waddr(msg_waddr_a),
    .msg_wdata(msg_wdata_a), .refresh(refresh_a), .busy(busy_a), .init_done(init_done_a),
    .db(db_a), .next_instruction(ni_a), .done(done_a | stray_a)
  );

  lcd_display_sequencer #(.T_PWRUP(100), .T_CMD(20), .T_CLEAR(50), .BOOT_REFRESH(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .msg_we(msg_we_b), .msg_waddr(msg_waddr_b),
    .msg_wdata(msg_wdata_b), .refresh(refresh_b), .busy(busy_b), .init_done(init_done_b),
    .db(db_b), .next_instruction(ni_b), .done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model and transfer log: done comes 40 cycles after each request.
  always @(negedge clk) begin
    done_a = (cyc == done_at_a);
    done_b = (cyc == done_at_b);
    if (ni_a) begin q_a.push_back(db_a); tq_a.push_back(cyc); done_at_a = cyc + 40; end
    if (ni_b) begin q_b.push_back(db_b); tq_b.push_back(cyc); done_at_b = cyc + 40; end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int qsize(input bit s);
    return s ? q_b.size() : q_a.size();
  endfunction
  function automatic int esize(input bit s);
    return s ? exp_b.size() : exp_a.size();
  endfunction
  function automatic logic [9:0] qdb(input bit s, input int k);
    return s ? q_b[k] : q_a[k];
  endfunction
  function automatic logic [9:0] edb(input bit s, input int k);
    return s ? exp_b[k] : exp_a[k];
  endfunction
  function automatic int qt(input bit s, input int k);
    return s ? tq_b[k] : tq_a[k];
  endfunction
  function automatic logic busy_of(input bit s);
    return s ? busy_b : busy_a;
  endfunction

  function automatic void push_exp(input bit s, input logic [9:0] v);
    if (s) exp_b.push_back(v);
    else   exp_a.push_back(v);
  endfunction

  function automatic void expect_init(input bit s);
    push_exp(s, 10'h028); push_exp(s, 10'h006); push_exp(s, 10'h00C); push_exp(s, 10'h001);
  endfunction

  // One redraw as the display sees it: line address, then 16 characters, per line.
  function automatic void expect_redraw(input bit s);
    for (int line = 0; line < 2; line++) begin
      push_exp(s, (line == 0) ? 10'h080 : 10'h0C0);
      for (int col = 0; col < 16; col++)
        push_exp(s, {2'b10, s ? mem_b[line*16+col] : mem_a[line*16+col]});
    end
  endfunction

  task automatic compare(input bit s, input int from, input int n, input string tag);
    for (int k = from; k < from + n; k++) begin
      if (k >= qsize(s) || k >= esize(s)) break;
      chk($sformatf("%s_db%0d", tag, k), qdb(s, k), edb(s, k));
      if (k > from)
        chk($sformatf("%s_gap%0d", tag, k), qt(s, k) - qt(s, k-1) - 40,
            (edb(s, k-1) == 10'h001) ? 51 : 21);
    end
  endtask

  task automatic wait_count(input bit s, input int n, input int budget, input string tag);
    int b = 0;
    while (qsize(s) < n && b < budget) begin tick(); b++; end
    chk(tag, qsize(s), n);
  endtask

  task automatic wait_idle(input bit s, input int budget, input string tag);
    int b = 0;
    while (busy_of(s) !== 1'b0 && b < budget) begin tick(); b++; end
    chk(tag, {31'd0, busy_of(s)}, 0);
  endtask

  task automatic rst_chk(input bit s, input string tag);
    chk({tag, "_db"},   s ? db_b : db_a, 0);
    chk({tag, "_ni"},   s ? ni_b : ni_a, 0);
    chk({tag, "_busy"}, s ? busy_b : busy_a, 1);
    chk({tag, "_idn"},  s ? init_done_b : init_done_a, 0);
  endtask

  task automatic pulse_refresh(input bit s);
    if (s) refresh_b = 1'b1; else refresh_a = 1'b1;
    tick();
    refresh_a = 1'b0;
    refresh_b = 1'b0;
  endtask

  initial begin
    int t0, r, p5, b;
    logic [7:0] new_c;
    reset_a = 1'b1; msg_we_a = 1'b0; msg_waddr_a = '0; msg_wdata_a = '0; refresh_a = 1'b0;
    reset_b = 1'b1; msg_we_b = 1'b0; msg_waddr_b = '0; msg_wdata_b = '0; refresh_b = 1'b0;
    stray_a = 1'b0;
    for (int i = 0; i < 32; i++) begin mem_a[i] = 8'h20; mem_b[i] = 8'h20; end
    repeat (3) tick();
    rst_chk(1'b0, "rst_a");
    rst_chk(1'b1, "rst_b");
    reset_a = 1'b0;
    reset_b = 1'b0;
    t0 = cyc;

    // Init and boot redraw on A, with two writes landing during power-up
    msg_we_a = 1'b1; msg_waddr_a = 5'd0;  msg_wdata_a = "H"; tick();
    msg_waddr_a = 5'd31; msg_wdata_a = "!"; tick();
    msg_we_a = 1'b0;
    mem_a[0] = "H"; mem_a[31] = "!";
    expect_init(1'b0); expect_redraw(1'b0);
    expect_init(1'b1);
    wait_count(1'b0, 1, 400, "a_first");
    chk("a_first_cycle", tq_a[0] - t0, 100);
    wait_count(1'b0, 4, 400, "a_init4");
    chk("a_idn_before", init_done_a, 0);
    chk("a_busy_init", busy_a, 1);
    wait_count(1'b0, 5, 400, "a_redraw_start");
    chk("a_idn_after", init_done_a, 1);
    wait_count(1'b0, 38, 3000, "a_redraw_end");
    wait_idle(1'b0, 200, "a_idle");
    compare(1'b0, 0, 38, "a_boot");

    // B: no auto redraw; random buffer contents; refresh from idle
    chk("b_no_boot", qsize(1'b1), 4);
    chk("b_idle", busy_b, 0);
    chk("b_idn", init_done_b, 1);
    compare(1'b1, 0, 4, "b_init");
    for (int i = 0; i < 32; i++) begin
      mem_b[i] = 8'($urandom_range(32, 126));
      msg_we_b = 1'b1; msg_waddr_b = 5'(i); msg_wdata_b = mem_b[i];
      tick();
    end
    msg_we_b = 1'b0;
    expect_redraw(1'b1);
    r = cyc;
    pulse_refresh(1'b1);
    wait_count(1'b1, 5, 50, "b_ref_start");
    chk("b_ref_latency", tq_b[4] - r, 2);
    wait_count(1'b1, 38, 3000, "b_ref_end");
    wait_idle(1'b1, 200, "b_ref_idle");
    compare(1'b1, 4, 34, "b_ref");

    // Three refreshes during a redraw collapse into one extra redraw
    expect_redraw(1'b1); expect_redraw(1'b1);
    pulse_refresh(1'b1);
    for (int j = 0; j < 3; j++) begin
      repeat ($urandom_range(20, 400)) tick();
      pulse_refresh(1'b1);
    end
    wait_count(1'b1, 106, 6000, "b_coal_end");
    wait_idle(1'b1, 200, "b_coal_idle");
    compare(1'b1, 38, 68, "b_coal");
    repeat (300) tick();
    chk("b_coal_extra", qsize(1'b1), 106);

    // Write to char 5 in the very cycle it is read: old char goes out, new one next time
    expect_redraw(1'b1);
    pulse_refresh(1'b1);
    wait_count(1'b1, 112, 1000, "b_rw_step5");
    p5 = tq_b[111];
    b = 0;
    while (cyc < p5 + 60 && b < 200) begin tick(); b++; end
    new_c = 8'($urandom_range(33, 126));
    if (new_c == mem_b[5]) new_c = new_c ^ 8'h01;
    msg_we_b = 1'b1; msg_waddr_b = 5'd5; msg_wdata_b = new_c;
    tick();
    msg_we_b = 1'b0;
    mem_b[5] = new_c;
    wait_count(1'b1, 140, 3000, "b_rw_end");
    wait_idle(1'b1, 200, "b_rw_idle");
    compare(1'b1, 106, 34, "b_rw_old");
    expect_redraw(1'b1);
    pulse_refresh(1'b1);
    wait_count(1'b1, 174, 3000, "b_rw2_end");
    wait_idle(1'b1, 200, "b_rw2_idle");
    compare(1'b1, 140, 34, "b_rw_new");
    chk("b_rw_newchar", qdb(1'b1, 146), {2'b10, new_c});

    // Reset A while it waits on char 7; engine's late done then lands in power-up
    pulse_refresh(1'b0);
    wait_count(1'b0, 47, 1000, "a_char7");
    repeat (5) tick();
    reset_a = 1'b1;
    tick();
    rst_chk(1'b0, "rst_mid_a");
    reset_a = 1'b0;
    t0 = cyc;
    q_a.delete(); tq_a.delete(); exp_a.delete();
    for (int i = 0; i < 32; i++) mem_a[i] = 8'h20;
    expect_init(1'b0); expect_redraw(1'b0);
    repeat (50) tick();
    stray_a = 1'b1;
    tick();
    stray_a = 1'b0;
    chk("a_pwrup_quiet", qsize(1'b0), 0);
    wait_count(1'b0, 1, 200, "a_re_first");
    chk("a_re_first_cycle", tq_a[0] - t0, 100);
    wait_count(1'b0, 38, 3500, "a_re_end");
    wait_idle(1'b0, 200, "a_re_idle");
    chk("a_re_idn", init_done_a, 1);
    compare(1'b0, 0, 38, "a_re");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
